// File: rtl/issue_scheduler.sv
// issue_scheduler: age-ordered dual-issue selector with unit-conflict rules,
// a one-cycle pending mask for entries already on the issue outputs, and a
// non-pipelined divider occupancy counter.
module issue_scheduler #(
  parameter  int BUF_SIZE_LOG = 4,
  parameter  int DIV_LATENCY  = 33,
  localparam int BUF_SIZE     = 1 << BUF_SIZE_LOG
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [BUF_SIZE-1:0]                     entry_ready,
  input  logic [BUF_SIZE-1:0][2:0]                entry_unit,
  input  logic [BUF_SIZE-1:0][BUF_SIZE_LOG:0]     entry_tag,
  input  logic [BUF_SIZE_LOG-1:0]                 head_index,
  input  logic                                    flush,
  input  logic                                    ex_stall,
  output logic [1:0]                              issue_valid,
  output logic [1:0][BUF_SIZE_LOG-1:0]            issue_index,
  output logic [1:0][BUF_SIZE_LOG:0]              issue_tag,
  output logic                                    div_busy
);

  localparam logic [2:0] U_MUL   = 3'd2;
  localparam logic [2:0] U_DIV   = 3'd3;
  localparam logic [2:0] U_LOAD  = 3'd4;
  localparam logic [2:0] U_STORE = 3'd5;

  logic [BUF_SIZE-1:0]     r_pend;
  logic [5:0]              r_div_cnt;

  logic [BUF_SIZE-1:0]     w_cand;
  logic [BUF_SIZE-1:0]     w_mask;
  logic [BUF_SIZE_LOG-1:0] w_idx;
  logic                    w_v0, w_v1;
  logic [BUF_SIZE_LOG-1:0] w_s0, w_s1;
  logic [2:0]              w_u0, w_u1, w_u;
  logic                    w_conflict;
  logic                    w_div_sel;

  assign div_busy = (r_div_cnt != '0);

  // Candidate filter: ready, not already on the outputs, divider free for DIV.
  always_comb begin
    for (int i = 0; i < BUF_SIZE; i++)
      w_cand[i] = entry_ready[i] & ~r_pend[i] & ~((entry_unit[i] == U_DIV) & div_busy);
  end

  // Walk entries oldest-first from head; slot 0 gets the first candidate,
  // slot 1 the next one that does not collide with slot 0's unit.
  always_comb begin
    w_v0 = 1'b0;
    w_v1 = 1'b0;
    w_s0 = '0;
    w_s1 = '0;
    w_u0 = '0;
    w_u1 = '0;
    w_u  = '0;
    w_idx = '0;
    w_conflict = 1'b0;
    for (int k = 0; k < BUF_SIZE; k++) begin
      w_idx = head_index + BUF_SIZE_LOG'(k);
      w_u   = entry_unit[w_idx];
      w_conflict = ((w_u0 == U_MUL) && (w_u == U_MUL)) ||
                   ((w_u0 == U_DIV) && (w_u == U_DIV)) ||
                   (((w_u0 == U_LOAD) || (w_u0 == U_STORE)) &&
                    ((w_u == U_LOAD) || (w_u == U_STORE)));
      if (w_cand[w_idx]) begin
        if (!w_v0) begin
          w_v0 = 1'b1;
          w_s0 = w_idx;
          w_u0 = w_u;
        end else if (!w_v1 && !w_conflict) begin
          w_v1 = 1'b1;
          w_s1 = w_idx;
          w_u1 = w_u;
        end
      end
    end
  end

  // One-hot of this cycle's picks; becomes next cycle's pending mask.
  always_comb begin
    w_mask = '0;
    if (w_v0) w_mask[w_s0] = 1'b1;
    if (w_v1) w_mask[w_s1] = 1'b1;
    w_div_sel = (w_v0 && (w_u0 == U_DIV)) || (w_v1 && (w_u1 == U_DIV));
  end

  // Issue registers, pending mask and divider counter; reset > flush > stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_valid <= '0;
      issue_index <= '0;
      issue_tag   <= '0;
      r_pend      <= '0;
      r_div_cnt   <= '0;
    end else if (flush) begin
      issue_valid <= '0;
      issue_index <= '0;
      issue_tag   <= '0;
      r_pend      <= '0;
      r_div_cnt   <= '0;
    end else begin
      if (!ex_stall && w_div_sel)
        r_div_cnt <= 6'(DIV_LATENCY);
      else if (r_div_cnt != '0)
        r_div_cnt <= r_div_cnt - 6'd1;
      if (!ex_stall) begin
        issue_valid    <= {w_v1, w_v0};
        issue_index[0] <= w_v0 ? w_s0 : '0;
        issue_index[1] <= w_v1 ? w_s1 : '0;
        issue_tag[0]   <= w_v0 ? entry_tag[w_s0] : '0;
        issue_tag[1]   <= w_v1 ? entry_tag[w_s1] : '0;
        r_pend         <= w_mask;
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: vector table plus multi-cycle sequences.
module tb_issue_scheduler;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [15:0]           entry_ready;
  logic [15:0][2:0]      entry_unit;
  logic [15:0][4:0]      entry_tag;
  logic [3:0]            head_index;
  logic                  flush;
  logic                  ex_stall;
  logic [1:0]            issue_valid;
  logic [1:0][3:0]       issue_index;
  logic [1:0][4:0]       issue_tag;
  logic                  div_busy;

  int total = 0;
  int bad   = 0;

  issue_scheduler #(.BUF_SIZE_LOG(4), .DIV_LATENCY(33)) dut (
    .clk(clk), .reset(reset), .entry_ready(entry_ready), .entry_unit(entry_unit),
    .entry_tag(entry_tag), .head_index(head_index), .flush(flush), .ex_stall(ex_stall),
    .issue_valid(issue_valid), .issue_index(issue_index), .issue_tag(issue_tag),
    .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ready;
    logic [3:0]  head;
    logic [15:0] ldm, stm, mulm;
    logic [1:0]  ev;
    logic [3:0]  e0, e1;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Checks both slots; expected tag is index+16 when valid, else 0.
  task automatic chk_issue(input string name, input logic [1:0] ev,
                           input logic [3:0] e0, input logic [3:0] e1);
    chk({name, ".valid"}, int'(issue_valid), int'(ev));
    chk({name, ".idx0"},  int'(issue_index[0]), ev[0] ? int'(e0) : 0);
    chk({name, ".idx1"},  int'(issue_index[1]), ev[1] ? int'(e1) : 0);
    chk({name, ".tag0"},  int'(issue_tag[0]), ev[0] ? int'(e0) + 16 : 0);
    chk({name, ".tag1"},  int'(issue_tag[1]), ev[1] ? int'(e1) + 16 : 0);
  endtask

  function automatic vec_t mk(input logic [15:0] r, input logic [3:0] h,
                              input logic [15:0] ld, input logic [15:0] st,
                              input logic [15:0] mu, input logic [1:0] ev,
                              input logic [3:0] e0, input logic [3:0] e1);
    vec_t v;
    v.ready = r; v.head = h; v.ldm = ld; v.stm = st; v.mulm = mu;
    v.ev = ev; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic set_units(input logic [15:0] ld, input logic [15:0] st,
                           input logic [15:0] mu, input logic [15:0] dv);
    for (int i = 0; i < 16; i++)
      entry_unit[i] = ld[i] ? 3'd4 : st[i] ? 3'd5 : mu[i] ? 3'd2 : dv[i] ? 3'd3 : 3'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    tbl[0]  = mk(16'h800A, 4'd14, 16'h0,    16'h0,    16'h0,    2'b11, 4'd15, 4'd1);
    tbl[1]  = mk(16'h800A, 4'd14, 16'h0,    16'h0,    16'h0,    2'b01, 4'd3,  4'd0);
    tbl[2]  = mk(16'h0000, 4'd14, 16'h0,    16'h0,    16'h0,    2'b00, 4'd0,  4'd0);
    tbl[3]  = mk(16'h0000, 4'd14, 16'h0,    16'h0,    16'h0,    2'b00, 4'd0,  4'd0);
    tbl[4]  = mk(16'h0070, 4'd4,  16'h0010, 16'h0020, 16'h0,    2'b11, 4'd4,  4'd6);
    tbl[5]  = mk(16'h0020, 4'd4,  16'h0010, 16'h0020, 16'h0,    2'b01, 4'd5,  4'd0);
    tbl[6]  = mk(16'h0000, 4'd4,  16'h0,    16'h0,    16'h0,    2'b00, 4'd0,  4'd0);
    tbl[7]  = mk(16'h0007, 4'd0,  16'h0,    16'h0,    16'h0003, 2'b11, 4'd0,  4'd2);
    tbl[8]  = mk(16'h0002, 4'd0,  16'h0,    16'h0,    16'h0003, 2'b01, 4'd1,  4'd0);
    tbl[9]  = mk(16'h0000, 4'd0,  16'h0,    16'h0,    16'h0,    2'b00, 4'd0,  4'd0);
    tbl[10] = mk(16'h8001, 4'd15, 16'h0,    16'h0,    16'h0,    2'b11, 4'd15, 4'd0);
    tbl[11] = mk(16'h0000, 4'd15, 16'h0,    16'h0,    16'h0,    2'b00, 4'd0,  4'd0);
    tbl[12] = mk(16'h0284, 4'd5,  16'h0,    16'h0,    16'h0,    2'b11, 4'd7,  4'd9);
    tbl[13] = mk(16'h0000, 4'd5,  16'h0,    16'h0,    16'h0,    2'b00, 4'd0,  4'd0);
    tbl[14] = mk(16'h0700, 4'd8,  16'h0300, 16'h0,    16'h0,    2'b11, 4'd8,  4'd10);
    tbl[15] = mk(16'h0000, 4'd8,  16'h0,    16'h0,    16'h0,    2'b00, 4'd0,  4'd0);

    for (int i = 0; i < 16; i++) entry_tag[i] = 5'(i + 16);
    set_units(16'h0, 16'h0, 16'h0, 16'h0);
    entry_ready = 16'h0020; head_index = '0; flush = 0; ex_stall = 0;

    // Reset with a ready entry: outputs stay cleared.
    reset = 0;
    step(); step();
    chk_issue("reset", 2'b00, 4'd0, 4'd0);
    chk("reset.busy", int'(div_busy), 0);
    reset = 1;
    step();
    chk_issue("first_sel", 2'b01, 4'd5, 4'd0);
    entry_ready = '0;
    step();
    chk_issue("first_drain", 2'b00, 4'd0, 4'd0);

    // Table vectors.
    for (int i = 0; i < 16; i++) begin
      entry_ready = tbl[i].ready;
      head_index  = tbl[i].head;
      set_units(tbl[i].ldm, tbl[i].stm, tbl[i].mulm, 16'h0);
      step();
      chk_issue($sformatf("vec%0d", i), tbl[i].ev, tbl[i].e0, tbl[i].e1);
      chk($sformatf("vec%0d.busy", i), int'(div_busy), 0);
    end

    // Divider occupancy: entry 3 waits until the counter drains.
    head_index = 0;
    set_units(16'h0, 16'h0, 16'h0, 16'h000C);
    entry_ready = 16'h000C;
    step();
    chk_issue("div.first", 2'b01, 4'd2, 4'd0);
    chk("div.busy0", int'(div_busy), 1);
    entry_ready = 16'h0008;
    n = 1;
    for (int c = 0; c < 40 && div_busy; c++) begin
      step();
      if (div_busy) begin
        n++;
        chk("div.hold_valid", int'(issue_valid), 0);
      end
    end
    chk("div.busy_cycles", n, 33);
    step();
    chk_issue("div.second", 2'b01, 4'd3, 4'd0);
    chk("div.busy_again", int'(div_busy), 1);
    entry_ready = '0; flush = 1;
    step();
    flush = 0;
    chk_issue("div.flush", 2'b00, 4'd0, 4'd0);
    chk("div.flush_busy", int'(div_busy), 0);

    // Stall holds outputs, then selection resumes with pending mask kept.
    set_units(16'h0, 16'h0, 16'h0, 16'h0);
    entry_ready = 16'h0006;
    step();
    chk_issue("stall.pre", 2'b11, 4'd1, 4'd2);
    entry_ready = 16'h0008; ex_stall = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_issue($sformatf("stall.hold%0d", c), 2'b11, 4'd1, 4'd2);
    end
    ex_stall = 0;
    step();
    chk_issue("stall.resume", 2'b01, 4'd3, 4'd0);
    entry_ready = '0;
    step();
    chk_issue("stall.drain", 2'b00, 4'd0, 4'd0);

    // Flush in the middle of divider occupancy.
    set_units(16'h0, 16'h0, 16'h0, 16'h0001);
    entry_ready = 16'h0001;
    step();
    chk_issue("flush.div", 2'b01, 4'd0, 4'd0);
    entry_ready = '0;
    step(); step(); step();
    chk("flush.busy_pre", int'(div_busy), 1);
    entry_ready = 16'h0002; flush = 1; ex_stall = 1;
    step();
    flush = 0; ex_stall = 0;
    chk_issue("flush.kill", 2'b00, 4'd0, 4'd0);
    chk("flush.busy", int'(div_busy), 0);
    step();
    chk_issue("flush.alu", 2'b01, 4'd1, 4'd0);
    entry_ready = '0;
    step();

    // Reset in the middle of divider occupancy with valid issues.
    entry_ready = 16'h0003;
    step();
    chk_issue("rst.pre", 2'b11, 4'd0, 4'd1);
    chk("rst.busy_pre", int'(div_busy), 1);
    reset = 0; flush = 1;
    step();
    chk_issue("rst.clear", 2'b00, 4'd0, 4'd0);
    chk("rst.busy", int'(div_busy), 0);
    reset = 1; flush = 0; entry_ready = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter BUF_SIZE_LOG, default 4, log2 of buffer entry count (BUF_SIZE = 2**BUF_SIZE_LOG).
REQ-002 SHALL have parameter DIV_LATENCY, default 33, divider occupancy in cycles (range 2-63).
REQ-003 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset: asserted (0) on a rising edge clears all state.
REQ-005 SHALL have port entry_ready, input, BUF_SIZE, bit i = entry i is in S_NOT_EXECUTED with J_rdy and K_rdy set.
REQ-006 SHALL have port entry_unit, input, BUF_SIZE x 3, unit code per entry: ALU=0, BRANCH=1, MUL=2, DIV=3, LOAD=4, STORE=5.
REQ-007 SHALL have port entry_tag, input, BUF_SIZE x (BUF_SIZE_LOG+1), tag per entry.
REQ-008 SHALL have port head_index, input, BUF_SIZE_LOG, index of oldest live entry.
REQ-009 SHALL have port flush, input, 1, established-branch kill of speculative work this cycle.
REQ-010 SHALL have port ex_stall, input, 1, EX cannot accept new issue this cycle.
REQ-011 SHALL have ports issue_valid[2], output, 1 each, slot s carries a valid issue.
REQ-012 SHALL have ports issue_index[2], output, BUF_SIZE_LOG each, buffer index issued on slot s.
REQ-013 SHALL have ports issue_tag[2], output, BUF_SIZE_LOG+1 each, tag of issued entry.
REQ-014 SHALL have port div_busy, output, 1, divider occupied.

Function
REQ-015 Priority: age order, entry (head_index+k) mod BUF_SIZE ranks k; lower k = older = higher priority; wrap-around at BUF_SIZE-1 -> 0 required.
REQ-016 Candidate = entry_ready[i] AND not in pending mask AND unit constraints (REQ-018..020) satisfied.
REQ-017 Slot 0 takes oldest candidate; slot 1 takes next-oldest candidate compatible with slot 0's choice; at most 2 issues/cycle.
REQ-018 MUL: at most one MUL per cycle (pipelined, no occupancy).
REQ-019 DIV: at most one per cycle, only when div_busy=0; issuing DIV loads counter with DIV_LATENCY; counter decrements each cycle, div_busy = (counter != 0).
REQ-020 LOAD/STORE: at most one memory op per cycle across both slots.
REQ-021 Outputs registered: selection in cycle t appears on issue_* in cycle t+1 (latency 1).
REQ-022 Pending mask: indexes issued on cycle t+1 outputs SHALL be excluded from selection in cycle t+1 (buffer state not yet S_EXECUTING); mask cleared the following cycle.
REQ-023 ex_stall=1: issue_* outputs hold current values, no new selection, pending mask holds, div counter still decrements.
REQ-024 flush=1: next-cycle issue_valid[0..1]=0, pending mask cleared, div counter cleared to 0 (div_busy=0 next cycle); flush dominates ex_stall.
REQ-025 Slot 1 SHALL never be valid while slot 0 is invalid.
REQ-026 No candidates: issue_valid=0, index/tag outputs 0.
REQ-027 Same index SHALL never appear on both slots in one cycle.

Reset
REQ-028 reset=0 at a rising edge: issue_valid=0, issue_index=0, issue_tag=0, pending mask=0, div counter=0, div_busy=0; reset dominates flush and ex_stall.
REQ-029 First selection occurs in the cycle after reset deasserts; outputs valid the cycle after that.

Verification
REQ-030 head_index=14, entries 15,1,3 ready ALU -> next cycle slot0=15, slot1=1; following cycle slot0=3 (15,1 masked).
REQ-031 Entries 2,3 ready DIV, div_busy=0 -> slot0=2, slot1 invalid; div_busy=1 for 33 cycles; entry 3 issues on cycle after counter reaches 0.
REQ-032 Entries 4 LOAD, 5 STORE, 6 ALU ready, head=4 -> slot0=4, slot1=6.
REQ-033 Valid issue present, ex_stall=1 for 3 cycles -> issue_* stable 3 cycles; then ex_stall=0 -> new selection next cycle.
REQ-034 DIV issued, flush=1 on cycle 5 of occupancy with ALU entry ready -> next cycle issue_valid=0, div_busy=0; ALU entry issues cycle after.
REQ-035 reset=0 asserted mid-DIV with valid issues -> next cycle all outputs 0, div_busy=0.
